rbuffer_frame_ctrl: RTL and testbench

- Sequences the UART receive byte buffer: hunts for a frame header, writes incoming bytes into the buffer, then reads the stored frame back by address.
- Validates the frame and presents a decoded command to the host-side consumer over a valid/ready handshake.
- Sits between the UART receiver (byte strobe + data) and the buffer's write/address/read-data ports.
- Keeps a shadow copy of the buffer write pointer; the buffer itself has no clear.

---
 rtl/rbuffer_frame_ctrl.sv | 146 ++++++++++++++
 tb/tb_rbuffer_frame_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbuffer_frame_ctrl.sv
// UART receive-buffer frame controller: hunts for a header, writes frame bytes into the
// byte buffer, reads the frame back, validates the checksum and presents the command.
module rbuffer_frame_ctrl #(
  parameter int         FRAME_LEN      = 5,
  parameter int         WRAP           = 5,
  parameter logic [7:0] HEADER         = 8'hAA,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         TW             = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done_tick,
  input  logic [7:0]  rx_dout,
  output logic        buf_wr,
  output logic [7:0]  buf_w_data,
  output logic [2:0]  buf_address,
  input  logic [7:0]  buf_r_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [7:0]  frame_cmd,
  output logic [15:0] frame_arg,
  output logic        err_tick,
  output logic        timeout_tick,
  output logic        overrun_tick
);
  localparam int            CW       = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FRAME_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, PRESENT} state_t;

  state_t        state;
  logic [2:0]    wptr;
  logic [2:0]    base;
  logic [CW-1:0] cnt;
  logic [CW-1:0] idx;
  logic [TW-1:0] timer;
  logic [7:0]    cmd_b;
  logic [7:0]    arg_hi_b;
  logic [7:0]    arg_lo_b;
  logic          chk_ok;

  function automatic logic [2:0] wrap_inc(input logic [2:0] p);
    return (p == 3'(WRAP - 1)) ? 3'd0 : p + 3'd1;
  endfunction

  function automatic logic checksum_ok(input logic [7:0] c, input logic [7:0] hi,
                                       input logic [7:0] lo, input logic [7:0] sum);
    return sum == (c ^ hi ^ lo);
  endfunction

  // The checksum byte is taken straight off the read port in the final CHECK cycle.
  assign chk_ok = checksum_ok(cmd_b, arg_hi_b, arg_lo_b, buf_r_data);

  always_ff @(posedge clk) begin
    if (state == CHECK) begin
      if (idx == CW'(1)) cmd_b    <= buf_r_data;
      if (idx == CW'(2)) arg_hi_b <= buf_r_data;
      if (idx == CW'(3)) arg_lo_b <= buf_r_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wptr         <= '0;
      base         <= '0;
      cnt          <= '0;
      idx          <= '0;
      timer        <= '0;
      buf_wr       <= 1'b0;
      buf_w_data   <= '0;
      buf_address  <= '0;
      frame_valid  <= 1'b0;
      frame_cmd    <= '0;
      frame_arg    <= '0;
      err_tick     <= 1'b0;
      timeout_tick <= 1'b0;
      overrun_tick <= 1'b0;
    end else begin
      buf_wr       <= 1'b0;
      err_tick     <= 1'b0;
      timeout_tick <= 1'b0;
      overrun_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_done_tick && rx_dout == HEADER) begin
            buf_wr     <= 1'b1;
            buf_w_data <= rx_dout;
            wptr       <= wrap_inc(wptr);
            base       <= wptr;
            cnt        <= CW'(1);
            timer      <= '0;
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          if (cnt == FULL_CNT) begin
            // last byte is being written this cycle; read-back starts next cycle
            overrun_tick <= rx_done_tick;
            idx          <= '0;
            buf_address  <= base;
            state        <= CHECK;
          end else if (rx_done_tick) begin
            buf_wr     <= 1'b1;
            buf_w_data <= rx_dout;
            wptr       <= wrap_inc(wptr);
            cnt        <= cnt + 1'b1;
            timer      <= '0;
          end else if (timer == TMO_LAST) begin
            timeout_tick <= 1'b1;
            state        <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CHECK: begin
          overrun_tick <= rx_done_tick;
          if (idx == LAST_IDX) begin
            if (chk_ok) begin
              frame_cmd   <= cmd_b;
              frame_arg   <= {arg_hi_b, arg_lo_b};
              frame_valid <= 1'b1;
              state       <= PRESENT;
            end else begin
              err_tick <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            idx         <= idx + 1'b1;
            buf_address <= wrap_inc(buf_address);
          end
        end
        PRESENT: begin
          overrun_tick <= rx_done_tick;
          if (frame_ready) begin
            frame_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rbuffer_frame_ctrl.sv
// Bench for rbuffer_frame_ctrl: byte buffer model, event monitor and a frame-level
// reference model that predicts writes, pulses and decoded frames from the byte stream.
module tb_rbuffer_frame_ctrl;
  localparam int         FL   = 5;
  localparam int         WR   = 5;
  localparam int         TO   = 100;
  localparam int         MAXC = 16384;
  localparam logic [7:0] HDR  = 8'hAA;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_done_tick = 1'b0;
  logic [7:0]  rx_dout = 8'h00;
  logic        buf_wr;
  logic [7:0]  buf_w_data;
  logic [2:0]  buf_address;
  logic [7:0]  buf_r_data;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic [7:0]  frame_cmd;
  logic [15:0] frame_arg;
  logic        err_tick;
  logic        timeout_tick;
  logic        overrun_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  rbuffer_frame_ctrl #(.FRAME_LEN(FL), .WRAP(WR), .HEADER(HDR), .TIMEOUT_CYCLES(TO), .TW(16)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_dout(rx_dout),
    .buf_wr(buf_wr), .buf_w_data(buf_w_data), .buf_address(buf_address), .buf_r_data(buf_r_data),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_cmd(frame_cmd), .frame_arg(frame_arg),
    .err_tick(err_tick), .timeout_tick(timeout_tick), .overrun_tick(overrun_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte buffer with its own write pointer; no clear of contents.
  logic [7:0] mem [WR];
  int tb_wp;
  always @(posedge clk or posedge reset) begin
    if (reset) tb_wp <= 0;
    else if (buf_wr) begin
      mem[tb_wp] <= buf_w_data;
      tb_wp <= (tb_wp + 1) % WR;
    end
  end
  assign buf_r_data = (buf_address < 3'(WR)) ? mem[buf_address] : 8'h00;

  // Event word: {cycle, kind, data}; kinds 1 write, 2 err, 3 timeout, 4 overrun, 5 valid rise, 6 valid fall.
  function automatic logic [31:0] ev(input int c, input int k, input logic [7:0] d);
    logic [31:0] r;
    r = {c[19:0], k[3:0], d};
    return r;
  endfunction

  logic [31:0] ev_obs[$];
  logic [31:0] ev_exp[$];
  logic [31:0] got[$];
  logic [2:0]  addr_at [MAXC];
  logic        prev_v = 1'b0;

  always @(negedge clk) begin
    if (cyc < MAXC) addr_at[cyc] <= buf_address;
    if (buf_wr) ev_obs.push_back(ev(cyc, 1, buf_w_data));
    if (err_tick) ev_obs.push_back(ev(cyc, 2, 8'h00));
    if (timeout_tick) ev_obs.push_back(ev(cyc, 3, 8'h00));
    if (overrun_tick) ev_obs.push_back(ev(cyc, 4, 8'h00));
    if (frame_valid && !prev_v) ev_obs.push_back(ev(cyc, 5, frame_cmd));
    if (!frame_valid && prev_v) ev_obs.push_back(ev(cyc, 6, 8'h00));
    prev_v <= frame_valid;
  end

  // Reference model state: 0 hunting for header, 1 collecting, 2 frame complete/pending.
  int          m_mode = 0;
  int          m_wp = 0;
  int          m_base = 0;
  int          m_last = 0;
  int          m_done = 0;
  int          m_rd_cyc = 0;
  int          m_rd_base = 0;
  bit          m_err = 1'b0;
  logic [7:0]  m_frame[$];
  logic [7:0]  m_cmd = 8'h00;
  logic [15:0] m_arg = 16'h0000;
  logic [7:0]  seq[$];

  task automatic model_reset();
    m_mode = 0; m_wp = 0; m_frame.delete(); ev_exp.delete();
  endtask

  task automatic model_advance(input int now);
    if (m_mode == 1 && now > m_last + TO) begin
      ev_exp.push_back(ev(m_last + TO + 1, 3, 8'h00));
      m_mode = 0;
    end
    if (m_mode == 2 && m_err && now >= m_done + FL + 2) m_mode = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = cyc;
    model_advance(t);
    rx_dout = b;
    rx_done_tick = 1'b1;
    if (m_mode == 2) ev_exp.push_back(ev(t + 1, 4, 8'h00));
    else if (m_mode == 1 || b == HDR) begin
      if (m_mode == 0) begin m_base = m_wp; m_frame.delete(); m_mode = 1; end
      ev_exp.push_back(ev(t + 1, 1, b));
      m_frame.push_back(b);
      m_wp = (m_wp + 1) % WR;
      m_last = t;
      if (m_frame.size() == FL) begin
        m_mode = 2; m_done = t; m_rd_cyc = t + 2; m_rd_base = m_base;
        if (m_frame[4] == (m_frame[1] ^ m_frame[2] ^ m_frame[3])) begin
          m_err = 1'b0; m_cmd = m_frame[1]; m_arg = {m_frame[2], m_frame[3]};
          ev_exp.push_back(ev(t + FL + 2, 5, m_frame[1]));
        end else begin
          m_err = 1'b1;
          ev_exp.push_back(ev(t + FL + 2, 2, 8'h00));
        end
      end
    end
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic send_seq(input int gap);
    for (int j = 0; j < seq.size(); j++) begin
      if (j > 0) idle(gap - 1);
      send_byte(seq[j]);
    end
  endtask

  task automatic release_frame();
    frame_ready = 1'b1;
    ev_exp.push_back(ev(cyc + 1, 6, 8'h00));
    @(posedge clk); #1;
    frame_ready = 1'b0;
    m_mode = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({buf_wr, err_tick, timeout_tick, overrun_tick, frame_valid} !== 5'b0) begin
      n_bad++; $display("FAIL reset_strobes got %b required 00000", {buf_wr, err_tick, timeout_tick, overrun_tick, frame_valid});
    end
    n_cmp++;
    if ({buf_w_data, buf_address} !== 11'h0) begin
      n_bad++; $display("FAIL reset_buf got %h/%h required 0/0", buf_w_data, buf_address);
    end
    n_cmp++;
    if ({frame_cmd, frame_arg} !== 24'h0) begin
      n_bad++; $display("FAIL reset_frame got %h/%h required 0/0", frame_cmd, frame_arg);
    end
    #3 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int s;
    s = ev_obs.size(); ev_exp.delete();
    seq = '{8'hAA, 8'h10, 8'h12, 8'h34, 8'h36};
    send_seq(20);
    idle(FL + 1);
    n_cmp++;
    if ({frame_valid, frame_cmd, frame_arg} !== {1'b1, m_cmd, m_arg}) begin
      n_bad++; $display("FAIL basic_frame got %b/%h/%h required 1/%h/%h", frame_valid, frame_cmd, frame_arg, m_cmd, m_arg);
    end
    for (int i = 0; i < FL; i++) begin
      n_cmp++;
      if (addr_at[m_rd_cyc + i] !== 3'((m_rd_base + i) % WR)) begin
        n_bad++; $display("FAIL basic_addr[%0d] got %0d required %0d", i, addr_at[m_rd_cyc + i], (m_rd_base + i) % WR);
      end
    end
    release_frame();
    idle(2);
    model_advance(cyc);
    got.delete();
    for (int i = s; i < ev_obs.size(); i++) got.push_back(ev_obs[i]);
    got.sort(); ev_exp.sort();
    n_cmp++;
    if (got.size() != ev_exp.size()) begin n_bad++; $display("FAIL basic_events count got %0d required %0d", got.size(), ev_exp.size()); end
    for (int i = 0; i < ev_exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== ev_exp[i]) begin n_bad++; $display("FAIL basic_event[%0d] got %h required %h", i, got[i], ev_exp[i]); end
    end
  endtask

  task automatic test_header_hunt();
    int s;
    s = ev_obs.size(); ev_exp.delete();
    seq = '{8'h55, 8'h00, 8'hAA, 8'h01, 8'h00, 8'h02, 8'h03};
    send_seq(20);
    idle(FL + 1);
    n_cmp++;
    if ({frame_valid, frame_cmd, frame_arg} !== {1'b1, m_cmd, m_arg}) begin
      n_bad++; $display("FAIL hunt_frame got %b/%h/%h required 1/%h/%h", frame_valid, frame_cmd, frame_arg, m_cmd, m_arg);
    end
    release_frame();
    idle(2);
    model_advance(cyc);
    got.delete();
    for (int i = s; i < ev_obs.size(); i++) got.push_back(ev_obs[i]);
    got.sort(); ev_exp.sort();
    n_cmp++;
    if (got.size() != ev_exp.size()) begin n_bad++; $display("FAIL hunt_events count got %0d required %0d", got.size(), ev_exp.size()); end
    for (int i = 0; i < ev_exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== ev_exp[i]) begin n_bad++; $display("FAIL hunt_event[%0d] got %h required %h", i, got[i], ev_exp[i]); end
    end
  endtask

  task automatic test_checksum_err();
    int s;
    s = ev_obs.size(); ev_exp.delete();
    seq = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'hFF};
    send_seq(20);
    idle(FL + 1);
    n_cmp++;
    if ({err_tick, frame_valid, frame_cmd, frame_arg} !== {2'b10, m_cmd, m_arg}) begin
      n_bad++; $display("FAIL cksum_err got %b%b/%h/%h required 10/%h/%h", err_tick, frame_valid, frame_cmd, frame_arg, m_cmd, m_arg);
    end
    idle(2);
    seq = '{8'hAA, 8'h33, 8'h44, 8'h55, 8'h22};
    send_seq(20);
    idle(FL + 1);
    n_cmp++;
    if ({frame_valid, frame_cmd, frame_arg} !== {1'b1, m_cmd, m_arg}) begin
      n_bad++; $display("FAIL cksum_next got %b/%h/%h required 1/%h/%h", frame_valid, frame_cmd, frame_arg, m_cmd, m_arg);
    end
    release_frame();
    idle(2);
    model_advance(cyc);
    got.delete();
    for (int i = s; i < ev_obs.size(); i++) got.push_back(ev_obs[i]);
    got.sort(); ev_exp.sort();
    n_cmp++;
    if (got.size() != ev_exp.size()) begin n_bad++; $display("FAIL cksum_events count got %0d required %0d", got.size(), ev_exp.size()); end
    for (int i = 0; i < ev_exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== ev_exp[i]) begin n_bad++; $display("FAIL cksum_event[%0d] got %h required %h", i, got[i], ev_exp[i]); end
    end
  endtask

  task automatic test_timeout();
    int s;
    s = ev_obs.size(); ev_exp.delete();
    send_byte(8'hAA);
    idle(TO - 1);
    send_byte(8'h01);
    idle(TO + 10);
    seq = '{8'hAA, 8'h02, 8'h00, 8'h00, 8'h02};
    send_seq(20);
    idle(FL + 1);
    n_cmp++;
    if ({frame_valid, frame_cmd, frame_arg} !== {1'b1, m_cmd, m_arg}) begin
      n_bad++; $display("FAIL timeout_frame got %b/%h/%h required 1/%h/%h", frame_valid, frame_cmd, frame_arg, m_cmd, m_arg);
    end
    for (int i = 0; i < FL; i++) begin
      n_cmp++;
      if (addr_at[m_rd_cyc + i] !== 3'((m_rd_base + i) % WR)) begin
        n_bad++; $display("FAIL timeout_addr[%0d] got %0d required %0d", i, addr_at[m_rd_cyc + i], (m_rd_base + i) % WR);
      end
    end
    release_frame();
    idle(2);
    model_advance(cyc);
    got.delete();
    for (int i = s; i < ev_obs.size(); i++) got.push_back(ev_obs[i]);
    got.sort(); ev_exp.sort();
    n_cmp++;
    if (got.size() != ev_exp.size()) begin n_bad++; $display("FAIL timeout_events count got %0d required %0d", got.size(), ev_exp.size()); end
    for (int i = 0; i < ev_exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== ev_exp[i]) begin n_bad++; $display("FAIL timeout_event[%0d] got %h required %h", i, got[i], ev_exp[i]); end
    end
  endtask

  task automatic test_overrun();
    int s;
    s = ev_obs.size(); ev_exp.delete();
    seq = '{8'hAA, 8'h05, 8'hAB, 8'hCD, 8'h63};
    send_seq(15);
    idle(FL + 4);
    send_byte(8'h77);
    n_cmp++;
    if ({overrun_tick, buf_wr, frame_valid, frame_cmd, frame_arg} !== {3'b101, m_cmd, m_arg}) begin
      n_bad++; $display("FAIL overrun_hold got %b%b%b/%h/%h required 101/%h/%h", overrun_tick, buf_wr, frame_valid, frame_cmd, frame_arg, m_cmd, m_arg);
    end
    idle(2);
    release_frame();
    n_cmp++;
    if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL overrun_release got %b required 0", frame_valid); end
    idle(2);
    model_advance(cyc);
    got.delete();
    for (int i = s; i < ev_obs.size(); i++) got.push_back(ev_obs[i]);
    got.sort(); ev_exp.sort();
    n_cmp++;
    if (got.size() != ev_exp.size()) begin n_bad++; $display("FAIL overrun_events count got %0d required %0d", got.size(), ev_exp.size()); end
    for (int i = 0; i < ev_exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== ev_exp[i]) begin n_bad++; $display("FAIL overrun_event[%0d] got %h required %h", i, got[i], ev_exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int s;
    ev_exp.delete();
    seq = '{8'hAA, 8'h11, 8'h22};
    send_seq(20);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({buf_wr, err_tick, timeout_tick, overrun_tick, frame_valid, buf_w_data, buf_address} !== 16'h0) begin
      n_bad++; $display("FAIL resetmid_outputs got %b%b%b%b%b/%h/%h required 00000/0/0",
                        buf_wr, err_tick, timeout_tick, overrun_tick, frame_valid, buf_w_data, buf_address);
    end
    #3 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    s = ev_obs.size();
    seq = '{8'hAA, 8'h21, 8'h00, 8'h04, 8'h25};
    send_seq(10);
    idle(FL + 1);
    n_cmp++;
    if ({frame_valid, frame_cmd, frame_arg} !== {1'b1, m_cmd, m_arg}) begin
      n_bad++; $display("FAIL resetmid_frame got %b/%h/%h required 1/%h/%h", frame_valid, frame_cmd, frame_arg, m_cmd, m_arg);
    end
    for (int i = 0; i < FL; i++) begin
      n_cmp++;
      if (addr_at[m_rd_cyc + i] !== 3'((m_rd_base + i) % WR)) begin
        n_bad++; $display("FAIL resetmid_addr[%0d] got %0d required %0d", i, addr_at[m_rd_cyc + i], (m_rd_base + i) % WR);
      end
    end
    release_frame();
    idle(2);
    model_advance(cyc);
    got.delete();
    for (int i = s; i < ev_obs.size(); i++) got.push_back(ev_obs[i]);
    got.sort(); ev_exp.sort();
    n_cmp++;
    if (got.size() != ev_exp.size()) begin n_bad++; $display("FAIL resetmid_events count got %0d required %0d", got.size(), ev_exp.size()); end
    for (int i = 0; i < ev_exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== ev_exp[i]) begin n_bad++; $display("FAIL resetmid_event[%0d] got %h required %h", i, got[i], ev_exp[i]); end
    end
  endtask

  task automatic test_random();
    int s;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] sum;
    s = ev_obs.size(); ev_exp.delete();
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == HDR) b = 8'h3C;
        send_byte(b);
        idle(int'($urandom_range(0, 30)));
      end
      c = 8'($urandom_range(0, 255));
      hi = 8'($urandom_range(0, 255));
      lo = 8'($urandom_range(0, 255));
      sum = c ^ hi ^ lo;
      if ($urandom_range(0, 3) == 0) sum = ~sum;
      seq = '{HDR, c, hi, lo, sum};
      for (int j = 0; j < FL; j++) begin
        if (j > 0) idle(int'($urandom_range(1, TO)) - 1);
        send_byte(seq[j]);
      end
      idle(FL + 1);
      if (!m_err) begin
        n_cmp++;
        if ({frame_valid, frame_cmd, frame_arg} !== {1'b1, m_cmd, m_arg}) begin
          n_bad++; $display("FAIL random_frame[%0d] got %b/%h/%h required 1/%h/%h", k, frame_valid, frame_cmd, frame_arg, m_cmd, m_arg);
        end
        for (int i = 0; i < FL; i++) begin
          n_cmp++;
          if (addr_at[m_rd_cyc + i] !== 3'((m_rd_base + i) % WR)) begin
            n_bad++; $display("FAIL random_addr[%0d.%0d] got %0d required %0d", k, i, addr_at[m_rd_cyc + i], (m_rd_base + i) % WR);
          end
        end
        idle(int'($urandom_range(0, 4)));
        release_frame();
      end else begin
        n_cmp++;
        if ({err_tick, frame_valid} !== 2'b10) begin
          n_bad++; $display("FAIL random_err[%0d] got %b%b required 10", k, err_tick, frame_valid);
        end
      end
      idle(2);
    end
    model_advance(cyc);
    got.delete();
    for (int i = s; i < ev_obs.size(); i++) got.push_back(ev_obs[i]);
    got.sort(); ev_exp.sort();
    n_cmp++;
    if (got.size() != ev_exp.size()) begin n_bad++; $display("FAIL random_events count got %0d required %0d", got.size(), ev_exp.size()); end
    for (int i = 0; i < ev_exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== ev_exp[i]) begin n_bad++; $display("FAIL random_event[%0d] got %h required %h", i, got[i], ev_exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_header_hunt();
    test_checksum_err();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
